// File: rtl/echo_delay_sequencer.sv
// Echo delay-line sequencer: per sample, read the delayed tap, write the new sample, mix.
// Build option ECHO_FEEDBACK_EN writes the mixed output back into the line (regenerating echo).
module echo_delay_sequencer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int RAMP_STEP = 64
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [31:0]       delay_time,
  input  logic [31:0]       delay_volume,
  input  logic              disabled,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_out_valid,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, RD, WR, MIX} state_t;

  localparam int PW = DATA_W + 9;
  localparam logic [ADDR_W-1:0]       MAX_DELAY = '1;
  localparam logic [ADDR_W-1:0]       STEP      = ADDR_W'(RAMP_STEP);
  localparam logic signed [DATA_W+1:0] SAT_HI   = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W+1:0] SAT_LO   = {3'b111, {(DATA_W-1){1'b0}}};

  state_t state, state_nxt;

  logic [ADDR_W-1:0]        wr_ptr, cur_delay, tgt, ramp_delay;
  logic signed [DATA_W-1:0] in_r, tap_r, mix;
  logic [7:0]               vol, vol_r;
  logic                     dis_r;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W+1:0] echo, sum;

  assign busy = (state != IDLE);

  // Target is clamped to the line length; the effective delay slews toward it without overshoot.
  always_comb begin
    tgt = (delay_time > 32'(MAX_DELAY)) ? MAX_DELAY : delay_time[ADDR_W-1:0];
    if (tgt > cur_delay)
      ramp_delay = (tgt - cur_delay > STEP) ? cur_delay + STEP : tgt;
    else
      ramp_delay = (cur_delay - tgt > STEP) ? cur_delay - STEP : tgt;
    vol = (delay_volume > 32'd128) ? 8'd128 : delay_volume[7:0];
  end

  always_comb begin
    prod = tap_r * $signed({1'b0, vol_r});
    echo = $signed(prod[PW-1:7]);
    sum  = $signed({{2{in_r[DATA_W-1]}}, in_r}) + echo;
    if (sum > SAT_HI)
      mix = SAT_HI[DATA_W-1:0];
    else if (sum < SAT_LO)
      mix = SAT_LO[DATA_W-1:0];
    else
      mix = sum[DATA_W-1:0];
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        // The read is skipped on the pre-ramp delay, matching the address the line had last sample.
        if (sample_valid)
          state_nxt = (cur_delay == '0 || disabled) ? WR : RD;
      end
      RD: begin
        mem_req  = 1'b1;
        mem_addr = wr_ptr - cur_delay;
        if (mem_ack) state_nxt = WR;
      end
      WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wr_ptr;
`ifdef ECHO_FEEDBACK_EN
        mem_wdata = dis_r ? in_r : mix;
`else
        mem_wdata = in_r;
`endif
        if (mem_ack) state_nxt = MIX;
      end
      MIX: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr           <= '0;
      cur_delay        <= '0;
      in_r             <= '0;
      tap_r            <= '0;
      vol_r            <= '0;
      dis_r            <= 1'b0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      sample_out_valid <= 1'b0;
      if (state == IDLE && sample_valid) begin
        in_r      <= sample_in;
        dis_r     <= disabled;
        vol_r     <= vol;
        cur_delay <= ramp_delay;
        tap_r     <= '0;
      end
      if (state != IDLE && sample_valid) overrun <= 1'b1;
      if (state == RD && mem_ack) tap_r <= mem_rdata;
      if (state == WR && mem_ack) wr_ptr <= wr_ptr + 1'b1;
      if (state == MIX) begin
        sample_out       <= dis_r ? in_r : mix;
        sample_out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_echo_delay_sequencer.sv
// Scoreboard bench for echo_delay_sequencer with a wait-state-programmable RAM model.
module tb_echo_delay_sequencer;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [31:0] delay_time = '0;
  logic [31:0] delay_volume = '0;
  logic        disabled = 1'b0;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] sample_out;
  logic        sample_out_valid, busy, overrun;

  always #5 CLK = ~CLK;

  echo_delay_sequencer dut (
    .CLK(CLK), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .delay_time(delay_time), .delay_volume(delay_volume), .disabled(disabled),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .sample_out(sample_out),
    .sample_out_valid(sample_out_valid), .busy(busy), .overrun(overrun)
  );

  typedef struct { int out; int lat; int start; } res_t;
  typedef struct { bit we; int addr; int wdata; } acc_t;

`ifdef ECHO_FEEDBACK_EN
  localparam int EXP8  = 4000;
  localparam int EXP12 = 2000;
`else
  localparam int EXP8  = 0;
  localparam int EXP12 = 0;
`endif

  res_t res_q[$];
  acc_t acc_q[$];
  int   obs_out[$], obs_lat[$], obs_rd[$];
  logic [15:0] ram  [65536];
  logic [15:0] gram [65536];
  int total = 0, bad = 0, cyc = 0;
  int rd_wait = 0, wr_wait = 0, wcnt = 0, rd_cnt = 0, wr_cnt = 0;
  int m_cur = 0, m_ptr = 0;
  bit held = 1'b0;
  logic [15:0] h_addr, h_wdata;
  logic h_we;
  res_t r;
  acc_t a;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  assign mem_rdata = ram[mem_addr];
  assign mem_ack   = mem_req && (wcnt >= (mem_we ? wr_wait : rd_wait));
  always @(posedge CLK) wcnt <= (!mem_req || mem_ack) ? 0 : wcnt + 1;

  // Reference: expected accesses, output value and latency for one accepted sample.
  task automatic model(input int s, input int dt, input int dv, input bit dis);
    int tgt, vol, tap, mix, out, lat;
    bit skip;
    res_t rr;
    acc_t aa;
    skip = (m_cur == 0) || dis;
    tgt  = (dt > 65535) ? 65535 : dt;
    if (tgt > m_cur) m_cur = (tgt - m_cur > 64) ? m_cur + 64 : tgt;
    else             m_cur = (m_cur - tgt > 64) ? m_cur - 64 : tgt;
    vol = (dv > 128) ? 128 : (dv & 255);
    tap = 0;
    lat = 3 + wr_wait;
    if (!skip) begin
      aa.we = 1'b0; aa.addr = (m_ptr - m_cur) & 65535; aa.wdata = 0;
      acc_q.push_back(aa);
      tap = int'($signed(gram[aa.addr]));
      lat += 1 + rd_wait;
    end
    mix = s + ((tap * vol) >>> 7);
    if (mix > 32767)  mix = 32767;
    if (mix < -32768) mix = -32768;
    out = dis ? s : mix;
    aa.we = 1'b1; aa.addr = m_ptr;
`ifdef ECHO_FEEDBACK_EN
    aa.wdata = out;
`else
    aa.wdata = s;
`endif
    acc_q.push_back(aa);
    gram[m_ptr] = 16'(aa.wdata);
    m_ptr = (m_ptr + 1) & 65535;
    rr.out = out; rr.lat = lat; rr.start = cyc;
    res_q.push_back(rr);
  endtask

  task automatic send(input int s, input int dt, input int dv, input bit dis);
    @(posedge CLK); #1;
    sample_in = 16'(s); delay_time = 32'(dt); delay_volume = 32'(dv);
    disabled = dis; sample_valid = 1'b1;
    model(s, dt, dv, dis);
    @(posedge CLK); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && (res_q.size() != 0 || busy); i++) begin
      @(posedge CLK); #1;
    end
    check({tag, "_drain"}, res_q.size() + acc_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    rst_n = 1'b0; sample_valid = 1'b0; disabled = 1'b0;
    res_q.delete(); acc_q.delete(); obs_out.delete(); obs_lat.delete(); obs_rd.delete();
    foreach (ram[i]) begin ram[i] = '0; gram[i] = '0; end
    m_cur = 0; m_ptr = 0; rd_cnt = 0; wr_cnt = 0; rd_wait = 0; wr_wait = 0;
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (!rst_n) held = 1'b0;
    else begin
      if (sample_out_valid) begin
        check("out_pending", res_q.size() > 0, 1);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          check("out", $signed(sample_out), r.out);
          check("lat", cyc - r.start, r.lat);
          obs_out.push_back(int'($signed(sample_out)));
          obs_lat.push_back(cyc - r.start);
        end
      end
      if (mem_req && held) begin
        check("hold_addr", mem_addr, h_addr);
        check("hold_we", mem_we, h_we);
        check("hold_wdata", mem_wdata, h_wdata);
      end
      if (mem_req && mem_ack) begin
        if (mem_we) begin ram[mem_addr] = mem_wdata; wr_cnt++; end
        else begin rd_cnt++; obs_rd.push_back(int'(mem_addr)); end
        check("acc_pending", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          check("acc_we", mem_we, a.we);
          check("acc_addr", mem_addr, a.addr);
          if (a.we) check("acc_wdata", $signed(mem_wdata), a.wdata);
        end
      end
      held = mem_req && !mem_ack;
      h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", sample_out_valid, 0);
    check("rst_ovr", overrun, 0);
    check("rst_out", sample_out, 0);
    do_reset();

    // Reset asserted while a read is waiting for its ack.
    rd_wait = 20;
    send(100, 4, 64, 0); wait_idle("t1a");
    send(5, 4, 64, 0);
    check("t1_req_pre", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_req", mem_req, 0);
    check("t1_busy", busy, 0);
    check("t1_addr", mem_addr, 0);
    check("t1_out", sample_out, 0);
    check("t1_valid", sample_out_valid, 0);
    do_reset();

    // Impulse through a 4-sample delay at half gain.
    for (int i = 0; i < 13; i++) begin
      send((i == 0) ? 16000 : 0, 4, 64, 0);
      wait_idle("t2");
    end
    check("t2_o0", obs_out[0], 16000);
    check("t2_o1", obs_out[1], 0);
    check("t2_o4", obs_out[4], 8000);
    check("t2_o8", obs_out[8], EXP8);
    check("t2_o12", obs_out[12], EXP12);
    check("t2_lat0", obs_lat[0], 3);
    check("t2_lat1", obs_lat[1], 4);

    // Ramp toward 1000 with read-address wrap, then clamp above DEPTH-1 and ramp back.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(((i * 1237) % 20000) - 10000, 1000, 200, 0);
      wait_idle("t3");
    end
    check("t3_rd_first", obs_rd[0], 65409);
    check("t3_rd_last", obs_rd[18], 64555);
    for (int i = 0; i < 3; i++) begin send(i * 100, 1 << 20, 90, 0); wait_idle("t3c"); end
    for (int i = 0; i < 3; i++) begin send(-i * 50, 10, 128, 0); wait_idle("t3d"); end

    // Saturation both ways; bypass samples load raw taps and skip the read.
    do_reset();
    send(30000, 1, 128, 1);  wait_idle("t4a");
    send(30000, 1, 128, 0);  wait_idle("t4b");
    send(-30000, 1, 128, 1); wait_idle("t4c");
    send(-30000, 1, 128, 0); wait_idle("t4d");
    check("t4_pos", obs_out[1], 32767);
    check("t4_neg", obs_out[3], -32768);
    check("t6_bypass", obs_out[2], -30000);
    check("t6_reads", rd_cnt, 2);
    check("t6_writes", wr_cnt, 4);

    // Slow read ack, plus a sample arriving while busy.
    do_reset();
    rd_wait = 3;
    send(1000, 2, 64, 0); wait_idle("t5a");
    send(2000, 2, 64, 0);
    sample_in = 16'd777; sample_valid = 1'b1;
    @(posedge CLK); #1;
    sample_valid = 1'b0;
    check("t5_ovr", overrun, 1);
    wait_idle("t5b");
    check("t5_lat", obs_lat[1], 7);
    check("t5_reads", rd_cnt, 1);
    check("t5_writes", wr_cnt, 2);
    send(-4000, 2, 64, 0); wait_idle("t5c");
    check("t5_ovr_sticky", overrun, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
